instr_fetch_unit: RTL

- Fetch stage directly upstream of the multicycle control unit. Owns the PC and instruction register, and reads instruction memory through a variable-latency req/ack handshake.
- Drives opcode and Instr31_0 into the control unit.
- The control unit's fetch and PC-write signals drive fetch_req and pc_write; the datapath supplies branch_target.
- Flags misaligned PC and memory timeout as a sticky fault.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and instruction register, reads instruction memory over a
// variable-latency req/ack handshake, and latches a sticky fault on misalignment or timeout.
module instr_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            pc_write,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_rd,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr31_0,
    output logic [6:0]      opcode,
    output logic            instr_valid,
    output logic            fetch_done,
    output logic            fetch_busy,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       start;
    logic       load;
    logic       pc_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_rd     = 1'b0;
        fetch_busy  = 1'b0;
        fetch_done  = 1'b0;
        fetch_fault = 1'b0;
        accept      = 1'b0;
        start       = 1'b0;
        load        = 1'b0;
        pc_en       = 1'b0;
        case (state)
            IDLE: begin
                pc_en = pc_write;
                if (fetch_req) begin
                    start = 1'b1;
                    // A misaligned PC faults without ever touching memory.
                    if (pc[1:0] == 2'b00) begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = FAULT;
                    end
                end
            end
            REQ: begin
                imem_rd    = 1'b1;
                fetch_busy = 1'b1;
                if (imem_ack) begin
                    load      = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nxt = FAULT;
                end
            end
            DONE: begin
                fetch_done = 1'b1;
                pc_en      = pc_write;
                state_nxt  = IDLE;
            end
            FAULT: begin
                fetch_fault = 1'b1;
                pc_en       = pc_write;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            imem_addr   <= '0;
            Instr31_0   <= '0;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (pc_en) begin
                pc <= pc_src ? branch_target : pc + XLEN'(4);
            end
            // Address is captured from the pre-update PC even when pc_write fires on the same edge.
            if (accept) begin
                imem_addr <= pc;
                wait_cnt  <= '0;
            end else if (state == REQ && !imem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (load) begin
                Instr31_0   <= imem_rdata;
                instr_valid <= 1'b1;
            end else if (start) begin
                instr_valid <= 1'b0;
            end
        end
    end

    assign opcode = Instr31_0[6:0];

endmodule
